polygon_loader: RTL and testbench
=================================

# polygon_loader

Double-buffered vertex store that sits directly upstream of the point-in-polygon tester. It accepts one polygon as a serial valid/ready stream of world-coordinate vertices into a shadow bank. On a frame-boundary pulse it commits the complete polygon to the active bank. The active bank drives the tester's parallel vertex arrays and vertex count, so those arrays never change mid-frame.

## Interface
Parameters:
- WORLD_BITS, 32, signed width of one world coordinate.
- MAX_NUM_VERTICES, 32, capacity of each bank.

Ports:
- clk_in  input  1  system clock; single clock domain.
- rst_in  input  1  reset; synchronous, active-high.
- vertex_valid_in  input  1  vertex beat present.
- vertex_ready_out  output  1  loader can accept a beat.
- vertex_x_in  input  WORLD_BITS signed  vertex x.
- vertex_y_in  input  WORLD_BITS signed  vertex y.
- vertex_last_in  input  1  final vertex of the polygon.
- frame_swap_in  input  1  one-cycle frame-boundary pulse; commit request.
- poly_xs_out  output  WORLD_BITS signed x MAX_NUM_VERTICES  active-bank x values.
- poly_ys_out  output  WORLD_BITS signed x MAX_NUM_VERTICES  active-bank y values.
- num_points_out  output  $clog2(MAX_NUM_VERTICES+1)  active vertex count.
- pending_out  output  1  shadow bank holds a complete polygon awaiting commit.
- overflow_out  output  1  one-cycle pulse when a polygon is truncated.

## Operation
- A beat transfers only when vertex_valid_in && vertex_ready_out.
- State FILL: ready=1.
  - Each beat writes the shadow bank at wr_idx; wr_idx then increments.
  - A beat with last=1 sets shadow_count=wr_idx+1 and moves to PENDING.
  - A beat at wr_idx=MAX_NUM_VERTICES-1 with last=0:
    - sets shadow_count=MAX_NUM_VERTICES;
    - pulses overflow_out for the following cycle;
    - moves to DRAIN.
- State DRAIN: ready=1.
  - Accepted beats are discarded.
  - A beat with last=1 moves to PENDING.
- State PENDING: ready=0 and pending_out=1.
  - On frame_swap_in, the active bank is updated on the next edge:
    - active[i] = shadow[i] for i < shadow_count;
    - active[i] = 0 for i >= shadow_count;
    - num_points_out = shadow_count.
  - wr_idx clears to 0 and the state returns to FILL.
- frame_swap_in in FILL or DRAIN is ignored; the active bank and count are unchanged.
- A last beat in the same cycle as frame_swap_in:
  - the beat is accepted and the state enters PENDING;
  - that swap is not applied; the commit waits for the next frame_swap_in.
- No geometric filtering is applied. Counts of 1 or 2 are committed as-is.
- Coordinates pass bit-exact with no sign extension or scaling.
- Reset (any cycle, including mid-polygon or while PENDING):
  - state=FILL, wr_idx=0, shadow_count=0;
  - all active entries, num_points_out, pending_out and overflow_out = 0;
  - vertex_ready_out=0 during the reset cycle and 1 from the first cycle after rst_in deasserts;
  - partially loaded vertices are lost.

## Timing
- All outputs are registered.
- vertex_ready_out is a pure function of state, with no combinational path from vertex_valid_in.
- Commit latency: a swap pulse in cycle t makes new poly_*_out and num_points_out visible in cycle t+1.
- The first new beat can be accepted in cycle t+1.
- pending_out rises the cycle after the last beat and falls in cycle t+1 after the swap.
- overflow_out is high for exactly one cycle, the cycle after the truncating beat.
- Sustained throughput is 1 vertex/cycle in FILL/DRAIN.
- Minimum load time for an N-vertex polygon is N cycles.

## Test plan
- Load and commit a square:
  - stimulus: reset; stream (0,0),(10,0),(10,10),(0,10) with last on the 4th beat; pulse swap 3 cycles later;
  - required: num_points_out=4 one cycle after swap; xs=[0,10,10,0,0...]; ys=[0,0,10,10,0...]; pending_out high exactly from last+1 to swap.
- Swap ignored while filling:
  - stimulus: commit a triangle; start a pentagon; pulse swap after 2 beats;
  - required: outputs still show the triangle, count=3; after last and a second swap, count=5 and entries 5+ are zero.
- Backpressure:
  - stimulus: hold valid high in PENDING for 10 cycles;
  - required: ready=0 throughout and no shadow writes; after swap, the first beat lands at index 0.
- Overflow with MAX_NUM_VERTICES=4:
  - stimulus: stream 6 beats, last on the 6th;
  - required: overflow_out pulses once after beat 4; beats 5-6 are dropped; after swap, count=4 holding beats 1-4.
- Simultaneous last and swap:
  - stimulus: last beat and frame_swap_in in the same cycle;
  - required: active unchanged that frame; the next swap commits the new polygon.
- Reset mid-load:
  - stimulus: assert rst_in during the 3rd beat of a committed-then-reloading sequence;
  - required: all outputs 0 the next cycle, ready returns 1 the following cycle, and a fresh polygon loads from index 0.

Source files
------------

// File: rtl/polygon_loader.sv
// -----------------------------------------------------------------------------
// polygon_loader
//
// Double-buffered vertex store feeding the point-in-polygon tester. A polygon
// arrives as a serial valid/ready stream of world-coordinate vertices and is
// written into a shadow bank. When the shadow bank holds a complete polygon,
// a frame-boundary pulse copies it into the active bank. The active bank drives
// the tester's parallel vertex arrays, so they only change at frame boundaries.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous, active-high reset
//   vertex_valid_in   vertex beat present
//   vertex_ready_out  loader can accept a beat (registered, state-derived)
//   vertex_x_in       vertex x, signed WORLD_BITS
//   vertex_y_in       vertex y, signed WORLD_BITS
//   vertex_last_in    final vertex of the polygon
//   frame_swap_in     one-cycle frame-boundary pulse, commit request
//   poly_xs_out       active-bank x values, entry i at [i*WORLD_BITS +: WORLD_BITS]
//   poly_ys_out       active-bank y values, same packing as poly_xs_out
//   num_points_out    active vertex count
//   pending_out       shadow bank holds a complete polygon awaiting commit
//   overflow_out      one-cycle pulse after a polygon is truncated
// -----------------------------------------------------------------------------
module polygon_loader #(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     vertex_valid_in,
  output logic                                     vertex_ready_out,
  input  logic signed [WORLD_BITS-1:0]             vertex_x_in,
  input  logic signed [WORLD_BITS-1:0]             vertex_y_in,
  input  logic                                     vertex_last_in,
  input  logic                                     frame_swap_in,
  output logic [MAX_NUM_VERTICES*WORLD_BITS-1:0]   poly_xs_out,
  output logic [MAX_NUM_VERTICES*WORLD_BITS-1:0]   poly_ys_out,
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]    num_points_out,
  output logic                                     pending_out,
  output logic                                     overflow_out
);

  localparam int CNT_W = $clog2(MAX_NUM_VERTICES + 1);
  localparam int IDX_W = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NUM_VERTICES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_NUM_VERTICES);

  // FILL    : writing beats into the shadow bank
  // DRAIN   : polygon truncated, discarding beats up to and including last
  // PENDING : shadow bank complete, waiting for a frame swap
  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  logic [1:0]       state_q,        state_d;
  logic [IDX_W-1:0] wr_idx_q,       wr_idx_d;
  logic [CNT_W-1:0] shadow_count_q, shadow_count_d;
  logic             overflow_q,     overflow_d;
  logic             ready_q;
  logic             pending_q;

  logic signed [WORLD_BITS-1:0] shadow_x_q [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] shadow_y_q [MAX_NUM_VERTICES];

  logic [MAX_NUM_VERTICES*WORLD_BITS-1:0] act_xs_q;
  logic [MAX_NUM_VERTICES*WORLD_BITS-1:0] act_ys_q;
  logic [CNT_W-1:0]                       act_num_q;

  logic accept;
  logic shadow_we;
  logic commit;

  assign accept    = vertex_valid_in && ready_q;
  assign shadow_we = accept && (state_q == ST_FILL);
  // A swap only takes effect once the polygon is complete; a last beat that
  // coincides with a swap is still in FILL, so that swap is naturally ignored.
  assign commit    = frame_swap_in && (state_q == ST_PENDING);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d        = state_q;
    wr_idx_d       = wr_idx_q;
    shadow_count_d = shadow_count_q;
    overflow_d     = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (vertex_last_in) begin
            shadow_count_d = CNT_W'(wr_idx_q) + CNT_W'(1);
            state_d        = ST_PENDING;
          end else if (wr_idx_q == LAST_IDX) begin
            // Bank full but the polygon continues: keep what fits, drop the rest.
            shadow_count_d = FULL_CNT;
            overflow_d     = 1'b1;
            state_d        = ST_DRAIN;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (accept && vertex_last_in) begin
          state_d = ST_PENDING;
        end
      end

      ST_PENDING: begin
        if (frame_swap_in) begin
          wr_idx_d = '0;
          state_d  = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_FILL;
      wr_idx_q       <= '0;
      shadow_count_q <= '0;
      overflow_q     <= 1'b0;
      ready_q        <= 1'b0;
      pending_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_idx_q       <= wr_idx_d;
      shadow_count_q <= shadow_count_d;
      overflow_q     <= overflow_d;
      // Ready and pending are registered decodes of the next state, so they
      // track the state exactly while having no combinational path from
      // vertex_valid_in to vertex_ready_out.
      ready_q        <= (state_d != ST_PENDING);
      pending_q      <= (state_d == ST_PENDING);
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow bank
  // ---------------------------------------------------------------------------
  // NOTE: the shadow storage is deliberately not reset; entries at or beyond
  // shadow_count are never copied out, so stale contents are harmless and the
  // array can map onto plain flops or RAM without a reset network.
  always_ff @(posedge clk_in) begin
    if (shadow_we) begin
      shadow_x_q[wr_idx_q] <= vertex_x_in;
      shadow_y_q[wr_idx_q] <= vertex_y_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Active bank
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      act_xs_q  <= '0;
      act_ys_q  <= '0;
      act_num_q <= '0;
    end else if (commit) begin
      // Entries past the new count are zeroed so a shorter polygon never
      // leaves vertices of the previous one visible to the tester.
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        if (CNT_W'(i) < shadow_count_q) begin
          act_xs_q[i*WORLD_BITS +: WORLD_BITS] <= shadow_x_q[i];
          act_ys_q[i*WORLD_BITS +: WORLD_BITS] <= shadow_y_q[i];
        end else begin
          act_xs_q[i*WORLD_BITS +: WORLD_BITS] <= '0;
          act_ys_q[i*WORLD_BITS +: WORLD_BITS] <= '0;
        end
      end
      act_num_q <= shadow_count_q;
    end
  end

  assign vertex_ready_out = ready_q;
  assign pending_out      = pending_q;
  assign overflow_out     = overflow_q;
  assign poly_xs_out      = act_xs_q;
  assign poly_ys_out      = act_ys_q;
  assign num_points_out   = act_num_q;

endmodule

// File: tb/tb_polygon_loader.sv
// -----------------------------------------------------------------------------
// tb_polygon_loader
//
// Directed bench for polygon_loader. One instance uses an 8-entry bank for the
// main scenarios; a second 4-entry instance covers truncation. Inputs are
// driven and outputs sampled on the falling edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_polygon_loader;

  localparam int WB  = 32;
  localparam int NV  = 8;
  localparam int SNV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main instance (8 entries)
  logic                  valid, ready, last, swap, pending, overflow;
  logic signed [WB-1:0]  x, y;
  logic [NV*WB-1:0]      xs, ys;
  logic [3:0]            num;

  // Small instance (4 entries)
  logic                  s_valid, s_ready, s_last, s_swap, s_pending, s_overflow;
  logic signed [WB-1:0]  s_x, s_y;
  logic [SNV*WB-1:0]     s_xs, s_ys;
  logic [2:0]            s_num;

  int errors = 0;
  int checks = 0;

  polygon_loader #(.WORLD_BITS(WB), .MAX_NUM_VERTICES(NV)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .vertex_valid_in  (valid),
    .vertex_ready_out (ready),
    .vertex_x_in      (x),
    .vertex_y_in      (y),
    .vertex_last_in   (last),
    .frame_swap_in    (swap),
    .poly_xs_out      (xs),
    .poly_ys_out      (ys),
    .num_points_out   (num),
    .pending_out      (pending),
    .overflow_out     (overflow)
  );

  polygon_loader #(.WORLD_BITS(WB), .MAX_NUM_VERTICES(SNV)) dut_small (
    .clk_in           (clk),
    .rst_in           (rst),
    .vertex_valid_in  (s_valid),
    .vertex_ready_out (s_ready),
    .vertex_x_in      (s_x),
    .vertex_y_in      (s_y),
    .vertex_last_in   (s_last),
    .frame_swap_in    (s_swap),
    .poly_xs_out      (s_xs),
    .poly_ys_out      (s_ys),
    .num_points_out   (s_num),
    .pending_out      (s_pending),
    .overflow_out     (s_overflow)
  );

  function automatic logic signed [WB-1:0] ax(input int i);
    return xs[i*WB +: WB];
  endfunction

  function automatic logic signed [WB-1:0] ay(input int i);
    return ys[i*WB +: WB];
  endfunction

  function automatic logic signed [WB-1:0] sx(input int i);
    return s_xs[i*WB +: WB];
  endfunction

  function automatic logic signed [WB-1:0] sy(input int i);
    return s_ys[i*WB +: WB];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic signed [WB-1:0] bx, input logic signed [WB-1:0] by,
                      input logic bl);
    valid = 1'b1; x = bx; y = by; last = bl;
    tick();
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL reset_num: got %0d expected 0", num); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (xs !== '0 || ys !== '0) begin errors++; $display("FAIL reset_bank: got xs=%h ys=%h expected 0", xs, ys); end
    checks++; if (s_ready !== 1'b0 || s_num !== 3'd0) begin errors++; $display("FAIL reset_small: got ready=%b num=%0d expected 0/0", s_ready, s_num); end
    rst = 1'b0;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", ready); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_small_ready_after: got %b expected 1", s_ready); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_square();
    logic signed [WB-1:0] ex [NV];
    logic signed [WB-1:0] ey [NV];
    ex = '{0, 10, 10, 0, 0, 0, 0, 0};
    ey = '{0, 0, 10, 10, 0, 0, 0, 0};
    beat(0, 0, 1'b0);
    beat(10, 0, 1'b0);
    beat(10, 10, 1'b0);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL square_pending_early: got %b expected 0", pending); end
    beat(0, 10, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL square_pending_wait%0d: got %b expected 1", c, pending); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL square_ready_wait%0d: got %b expected 0", c, ready); end
      checks++; if (num !== 4'd0) begin errors++; $display("FAIL square_num_wait%0d: got %0d expected 0", c, num); end
      if (c == 2) swap = 1'b1;
      tick();
    end
    swap = 1'b0;
    checks++; if (num !== 4'd4) begin errors++; $display("FAIL square_num: got %0d expected 4", num); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL square_pending_after: got %b expected 0", pending); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL square_ready_after: got %b expected 1", ready); end
    for (int i = 0; i < NV; i++) begin
      checks++;
      if (ax(i) !== ex[i] || ay(i) !== ey[i]) begin
        errors++;
        $display("FAIL square_entry[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, ax(i), ay(i), ex[i], ey[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_swap_ignored_filling();
    logic signed [WB-1:0] px [NV];
    logic signed [WB-1:0] py [NV];
    px = '{-1, 32'sh7fffffff, 32'sh80000000, 7, -50, 0, 0, 0};
    py = '{100, -3, 0, 12345, -1, 0, 0, 0};
    beat(1, 2, 1'b0);
    beat(3, 4, 1'b0);
    beat(5, 6, 1'b1);
    do_swap();
    checks++; if (num !== 4'd3) begin errors++; $display("FAIL tri_num: got %0d expected 3", num); end
    beat(px[0], py[0], 1'b0);
    beat(px[1], py[1], 1'b0);
    do_swap();
    checks++; if (num !== 4'd3) begin errors++; $display("FAIL ignored_swap_num: got %0d expected 3", num); end
    checks++;
    if (ax(0) !== 1 || ax(1) !== 3 || ax(2) !== 5 || ay(2) !== 6) begin
      errors++;
      $display("FAIL ignored_swap_bank: got x=%0d,%0d,%0d y2=%0d expected x=1,3,5 y2=6", ax(0), ax(1), ax(2), ay(2));
    end
    beat(px[2], py[2], 1'b0);
    beat(px[3], py[3], 1'b0);
    beat(px[4], py[4], 1'b1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL penta_pending: got %b expected 1", pending); end
    do_swap();
    checks++; if (num !== 4'd5) begin errors++; $display("FAIL penta_num: got %0d expected 5", num); end
    for (int i = 0; i < NV; i++) begin
      checks++;
      if (ax(i) !== px[i] || ay(i) !== py[i]) begin
        errors++;
        $display("FAIL penta_entry[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, ax(i), ay(i), px[i], py[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    logic signed [WB-1:0] ex [NV];
    logic signed [WB-1:0] ey [NV];
    ex = '{21, 23, 0, 0, 0, 0, 0, 0};
    ey = '{22, 24, 0, 0, 0, 0, 0, 0};
    beat(11, 12, 1'b0);
    beat(13, 14, 1'b1);
    valid = 1'b1; x = 999; y = 999; last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0", c, ready); end
      tick();
    end
    swap = 1'b1;
    tick();
    swap = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_swap: got %b expected 1", ready); end
    checks++; if (num !== 4'd2) begin errors++; $display("FAIL bp_num: got %0d expected 2", num); end
    checks++;
    if (ax(0) !== 11 || ax(1) !== 13 || ay(1) !== 14) begin
      errors++;
      $display("FAIL bp_bank: got x=%0d,%0d y1=%0d expected x=11,13 y1=14", ax(0), ax(1), ay(1));
    end
    // First beat is presented in the cycle right after the swap.
    x = 21; y = 22;
    tick();
    x = 23; y = 24; last = 1'b1;
    tick();
    valid = 1'b0; last = 1'b0;
    do_swap();
    checks++; if (num !== 4'd2) begin errors++; $display("FAIL bp_reload_num: got %0d expected 2", num); end
    for (int i = 0; i < NV; i++) begin
      checks++;
      if (ax(i) !== ex[i] || ay(i) !== ey[i]) begin
        errors++;
        $display("FAIL bp_entry[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, ax(i), ay(i), ex[i], ey[i]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous();
    valid = 1'b1; x = 77; y = -77; last = 1'b1; swap = 1'b1;
    tick();
    valid = 1'b0; last = 1'b0; swap = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL simul_pending: got %b expected 1", pending); end
    checks++; if (num !== 4'd2) begin errors++; $display("FAIL simul_num_unchanged: got %0d expected 2", num); end
    checks++;
    if (ax(0) !== 21 || ax(1) !== 23) begin
      errors++;
      $display("FAIL simul_bank_unchanged: got x=%0d,%0d expected 21,23", ax(0), ax(1));
    end
    tick();
    checks++; if (num !== 4'd2) begin errors++; $display("FAIL simul_num_hold: got %0d expected 2", num); end
    do_swap();
    checks++; if (num !== 4'd1) begin errors++; $display("FAIL simul_num_commit: got %0d expected 1", num); end
    checks++; if (ax(0) !== 77 || ay(0) !== -77) begin errors++; $display("FAIL simul_entry0: got (%0d,%0d) expected (77,-77)", ax(0), ay(0)); end
    for (int i = 1; i < NV; i++) begin
      checks++;
      if (ax(i) !== 0 || ay(i) !== 0) begin
        errors++;
        $display("FAIL simul_cleared[%0d]: got (%0d,%0d) expected (0,0)", i, ax(i), ay(i));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_load();
    beat(31, 32, 1'b0);
    beat(33, 34, 1'b0);
    valid = 1'b1; x = 35; y = 36; last = 1'b0; rst = 1'b1;
    tick();
    valid = 1'b0; rst = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rml_ready: got %b expected 0", ready); end
    checks++; if (num !== 4'd0) begin errors++; $display("FAIL rml_num: got %0d expected 0", num); end
    checks++; if (pending !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rml_flags: got pending=%b overflow=%b expected 0/0", pending, overflow); end
    checks++; if (xs !== '0 || ys !== '0) begin errors++; $display("FAIL rml_bank: got xs=%h ys=%h expected 0", xs, ys); end
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rml_ready_back: got %b expected 1", ready); end
    beat(5, 6, 1'b0);
    beat(7, 8, 1'b1);
    do_swap();
    checks++; if (num !== 4'd2) begin errors++; $display("FAIL rml_fresh_num: got %0d expected 2", num); end
    checks++;
    if (ax(0) !== 5 || ay(0) !== 6 || ax(1) !== 7 || ay(1) !== 8 || ax(2) !== 0) begin
      errors++;
      $display("FAIL rml_fresh_bank: got (%0d,%0d),(%0d,%0d),x2=%0d expected (5,6),(7,8),x2=0",
               ax(0), ay(0), ax(1), ay(1), ax(2));
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overflow();
    for (int k = 1; k <= 6; k++) begin
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_beat%0d: got %b expected 1", k, s_ready); end
      s_valid = 1'b1; s_x = k; s_y = -k; s_last = (k == 6);
      tick();
      checks++;
      if (s_overflow !== (k == 4)) begin
        errors++;
        $display("FAIL ovf_pulse_after_beat%0d: got %b expected %b", k, s_overflow, (k == 4));
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (s_pending !== 1'b1) begin errors++; $display("FAIL ovf_pending: got %b expected 1", s_pending); end
    checks++; if (s_num !== 3'd0) begin errors++; $display("FAIL ovf_num_before: got %0d expected 0", s_num); end
    s_swap = 1'b1;
    tick();
    s_swap = 1'b0;
    checks++; if (s_num !== 3'd4) begin errors++; $display("FAIL ovf_num: got %0d expected 4", s_num); end
    for (int i = 0; i < SNV; i++) begin
      checks++;
      if (sx(i) !== i + 1 || sy(i) !== -(i + 1)) begin
        errors++;
        $display("FAIL ovf_entry[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, sx(i), sy(i), i + 1, -(i + 1));
      end
    end
    // Exact fit: last on the final slot is not a truncation.
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_x = 9 + k; s_y = 90 + k; s_last = (k == 3);
      tick();
      checks++; if (s_overflow !== 1'b0) begin errors++; $display("FAIL fit_no_ovf%0d: got %b expected 0", k, s_overflow); end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (s_pending !== 1'b1) begin errors++; $display("FAIL fit_pending: got %b expected 1", s_pending); end
    s_swap = 1'b1;
    tick();
    s_swap = 1'b0;
    checks++;
    if (s_num !== 3'd4 || sx(0) !== 9 || sx(3) !== 12 || sy(3) !== 93) begin
      errors++;
      $display("FAIL fit_commit: got num=%0d x0=%0d x3=%0d y3=%0d expected 4,9,12,93", s_num, sx(0), sx(3), sy(3));
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    valid = 1'b0; x = '0; y = '0; last = 1'b0; swap = 1'b0;
    s_valid = 1'b0; s_x = '0; s_y = '0; s_last = 1'b0; s_swap = 1'b0;

    test_reset();
    test_square();
    test_swap_ignored_filling();
    test_backpressure();
    test_simultaneous();
    test_overflow();
    test_reset_mid_load();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
